led_pattern_driver: RTL and testbench

Multi-channel LED pattern generator, the parametrised successor to the single-bit counter blinker used on the UPduino board designs. It drives `CHANNELS` LED pins, each independently configured to off, steady dimmed, blinking, or breathing. All channels share a PWM counter and a tick prescaler. It sits between the 48 MHz `SB_HFOSC` clock domain and the board LED pins, and is configured at run time through a valid/ready write port.

---
 rtl/led_pattern_driver.sv | 121 ++++++++++++
 tb/tb_led_pattern_driver.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_driver.sv
// Multi-channel LED pattern generator: off / steady / blink / breathe per channel,
// sharing one PWM counter, one tick prescaler and one blink phase.
module led_pattern_driver #(
   parameter  int CHANNELS    = 3,
   parameter  int PWM_BITS    = 8,
   parameter  int TICK_DIV    = 48000,
   parameter  int BLINK_TICKS = 250,
   localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CW-1:0]       cfg_chan,
   input  logic [1:0]          cfg_mode,
   input  logic [PWM_BITS-1:0] cfg_level,
   output logic [CHANNELS-1:0] led,
   output logic                tick
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

   localparam logic [1:0] M_OFF     = 2'd0;
   localparam logic [1:0] M_STEADY  = 2'd1;
   localparam logic [1:0] M_BLINK   = 2'd2;
   localparam logic [1:0] M_BREATHE = 2'd3;

   logic [PW-1:0]                     presc;
   logic [PWM_BITS-1:0]               pwm;
   logic [BW-1:0]                     bcnt;
   logic                              phase;
   logic [CHANNELS-1:0][1:0]          mode;
   logic [CHANNELS-1:0][PWM_BITS-1:0] level;
   logic [CHANNELS-1:0][PWM_BITS-1:0] duty;
   logic [CHANNELS-1:0]               up;
   logic [CHANNELS-1:0][PWM_BITS-1:0] eff;
   logic                              tick_evt;
   logic                              wr_en;

   assign tick_evt = (presc == PW'(TICK_DIV - 1));
   assign wr_en    = cfg_valid & cfg_ready;

   always_comb begin
      eff = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         unique case (mode[i])
            M_OFF:     eff[i] = '0;
            M_STEADY:  eff[i] = level[i];
            M_BLINK:   eff[i] = phase ? level[i] : '0;
            M_BREATHE: eff[i] = duty[i];
            default:   eff[i] = '0;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         cfg_ready <= 1'b0;
         tick      <= 1'b0;
         led       <= '0;
         presc     <= '0;
         pwm       <= '0;
         bcnt      <= '0;
         phase     <= 1'b0;
         mode      <= '0;
         level     <= '0;
         duty      <= '0;
         up        <= '1;
      end else begin
         cfg_ready <= 1'b1;
         tick      <= tick_evt;
         presc     <= tick_evt ? '0 : presc + 1'b1;
         pwm       <= pwm + 1'b1;
         if (tick_evt) begin
            if (bcnt == BW'(BLINK_TICKS - 1)) begin
               bcnt  <= '0;
               phase <= ~phase;
            end else begin
               bcnt <= bcnt + 1'b1;
            end
         end
         for (int i = 0; i < CHANNELS; i++) begin
            led[i] <= (pwm < eff[i]);
            // a write to this channel pre-empts the tick's breathe step
            if (wr_en && cfg_chan == CW'(i)) begin
               mode[i]  <= cfg_mode;
               level[i] <= cfg_level;
               if (cfg_mode == M_BREATHE) begin
                  if (mode[i] != M_BREATHE) begin
                     duty[i] <= '0;
                     up[i]   <= 1'b1;
                  end else if (cfg_level < duty[i]) begin
                     duty[i] <= cfg_level;
                     up[i]   <= 1'b0;
                  end
               end
            end else if (tick_evt && mode[i] == M_BREATHE) begin
               if (up[i]) begin
                  if (duty[i] < level[i]) begin
                     duty[i] <= duty[i] + 1'b1;
                     if (duty[i] + 1'b1 == level[i])
                        up[i] <= 1'b0;
                  end else begin
                     up[i] <= 1'b0;
                  end
               end else begin
                  if (duty[i] != '0) begin
                     duty[i] <= duty[i] - 1'b1;
                     if (duty[i] == PWM_BITS'(1))
                        up[i] <= 1'b1;
                  end else begin
                     up[i] <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed bench for led_pattern_driver with CHANNELS=3, PWM_BITS=4,
// TICK_DIV=4, BLINK_TICKS=2.
module tb_led_pattern_driver;

   localparam logic [1:0] M_OFF     = 2'd0;
   localparam logic [1:0] M_STEADY  = 2'd1;
   localparam logic [1:0] M_BLINK   = 2'd2;
   localparam logic [1:0] M_BREATHE = 2'd3;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       cfg_valid = 1'b0;
   logic       cfg_ready;
   logic [1:0] cfg_chan = '0;
   logic [1:0] cfg_mode = '0;
   logic [3:0] cfg_level = '0;
   logic [2:0] led;
   logic       tick;

   int n_cmp = 0;
   int n_bad = 0;
   int kcnt  = 0;

   led_pattern_driver #(
      .CHANNELS(3), .PWM_BITS(4), .TICK_DIV(4), .BLINK_TICKS(2)
   ) dut (
      .clock(clock), .reset(reset),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_level(cfg_level),
      .led(led), .tick(tick)
   );

   always #5 clock = ~clock;

   // edges since reset release; read on the falling edge
   always @(posedge clock) begin
      if (!reset) kcnt <= 0;
      else        kcnt <= kcnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [1:0] ch, input logic [1:0] m,
                     input logic [3:0] lv);
      cfg_valid = 1'b1;
      cfg_chan  = ch;
      cfg_mode  = m;
      cfg_level = lv;
      @(posedge clock);
      @(negedge clock);
      cfg_valid = 1'b0;
   endtask

   task automatic wait_mod(input int m, input int r);
      do @(negedge clock); while (kcnt % m != r);
   endtask

   task automatic count_hi(input int b, output int c);
      c = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clock);
         c += int'(led[b]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      logic [7:0]  tv;
      logic [15:0] bv;
      logic [3:0]  seq [9];
      logic [3:0]  tail [3];
      seq  = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0, 4'd1, 4'd2, 4'd3};
      tail = '{4'd0, 4'd1, 4'd0};

      @(negedge clock);
      chk("rst_led_1", led, 3'b000);
      chk("rst_ready_1", cfg_ready, 1'b0);
      repeat (2) @(negedge clock);
      chk("rst_led_3", led, 3'b000);
      chk("rst_ready_3", cfg_ready, 1'b0);
      reset = 1'b1;

      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         tv[i] = tick;
         if (i == 0) chk("ready_after", cfg_ready, 1'b1);
      end
      chk("tick_pattern", tv, 8'h88);
      chk("idle_led", led, 3'b000);

      wr(2'd0, M_STEADY, 4'd5);
      @(negedge clock);
      count_hi(0, c);
      chk("steady5", c, 5);
      wr(2'd0, M_STEADY, 4'd15);
      @(negedge clock);
      count_hi(0, c);
      chk("steady15", c, 15);
      wr(2'd0, M_STEADY, 4'd0);
      @(negedge clock);
      count_hi(0, c);
      chk("steady0", c, 0);

      wr(2'd1, M_BLINK, 4'd15);
      @(negedge clock);
      wait_mod(16, 0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clock);
         bv[i] = led[1];
      end
      chk("blink_pattern", bv, 16'h7F00);

      wait_mod(4, 1);
      wr(2'd2, M_BREATHE, 4'd3);
      for (int i = 0; i < 9; i++) begin
         wait_mod(4, 0);
         chk($sformatf("breathe_%0d", i), dut.duty[2], seq[i]);
      end
      wr(2'd2, M_BREATHE, 4'd1);
      chk("clamp_duty", dut.duty[2], 4'd1);
      chk("clamp_dir", dut.up[2], 1'b0);
      for (int i = 0; i < 3; i++) begin
         wait_mod(4, 0);
         chk($sformatf("clamp_seq_%0d", i), dut.duty[2], tail[i]);
      end

      wait_mod(4, 1);
      wr(2'd0, M_BREATHE, 4'd5);
      for (int i = 0; i < 3; i++) begin
         wait_mod(4, 0);
         chk($sformatf("ch0_up_%0d", i), dut.duty[0], i + 1);
      end
      wait_mod(4, 3);
      wr(2'd0, M_BREATHE, 4'd2);
      chk("race_tick", tick, 1'b1);
      chk("race_duty", dut.duty[0], 4'd2);
      chk("race_dir", dut.up[0], 1'b0);
      wait_mod(4, 0);
      chk("race_next", dut.duty[0], 4'd1);

      wr(2'd3, M_STEADY, 4'd7);
      chk("badchan_mode", dut.mode, 6'h3B);
      chk("badchan_level", dut.level, 12'h1F2);

      wait_mod(4, 2);
      reset     = 1'b0;
      cfg_valid = 1'b1;
      cfg_chan  = 2'd1;
      cfg_mode  = M_STEADY;
      cfg_level = 4'd9;
      @(negedge clock);
      cfg_valid = 1'b0;
      chk("mid_led", led, 3'b000);
      chk("mid_mode", dut.mode, 6'h00);
      chk("mid_level", dut.level, 12'h000);
      chk("mid_presc", dut.presc, 2'd0);
      chk("mid_tick", tick, 1'b0);
      chk("mid_ready", cfg_ready, 1'b0);
      chk("mid_duty", dut.duty, 12'h000);
      reset = 1'b1;
      @(negedge clock);
      chk("post_mode", dut.mode, 6'h00);
      chk("post_led", led, 3'b000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
